// File: rtl/csr_pkg.sv
// Shared CSR constants for the machine-mode interrupt path: addresses, interrupt
// bit positions and the mcause values reported for each interrupt source.
package csr_pkg;

  localparam int unsigned Xlen = 32;

  localparam logic [11:0] CSRmstatus = 12'h300;
  localparam logic [11:0] CSRmie     = 12'h304;
  localparam logic [11:0] CSRmip     = 12'h344;

  localparam int unsigned IntBitMSI = 3;
  localparam int unsigned IntBitMTI = 7;
  localparam int unsigned IntBitMEI = 11;

  localparam int unsigned MstatusMIE  = 3;
  localparam int unsigned MstatusMPIE = 7;

  localparam logic [Xlen-1:0] IntMask = {{(Xlen-12){1'b0}}, 12'h888};

  localparam logic [Xlen-1:0] IntCauseMEI = {1'b1, {(Xlen-5){1'b0}}, 4'd11};
  localparam logic [Xlen-1:0] IntCauseMSI = {1'b1, {(Xlen-5){1'b0}}, 4'd3};
  localparam logic [Xlen-1:0] IntCauseMTI = {1'b1, {(Xlen-5){1'b0}}, 4'd7};

  // Fixed priority: external beats software beats timer.
  function automatic logic [Xlen-1:0] irq_select(input logic [Xlen-1:0] eligible);
    if (eligible[IntBitMEI]) begin
      return IntCauseMEI;
    end else if (eligible[IntBitMSI]) begin
      return IntCauseMSI;
    end else if (eligible[IntBitMTI]) begin
      return IntCauseMTI;
    end
    return '0;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for a single asynchronous level.
module sync_ff #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d,
  output logic q
);

  logic [Depth-1:0] stages;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stages <= '0;
    end else begin
      stages <= {stages[Depth-2:0], d};
    end
  end

  assign q = stages[Depth-1];

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: owns mstatus.MIE/MPIE, mie and mip, and hands
// the highest-priority eligible interrupt to the pipeline via req/ack.
module irq_ctrl
  import csr_pkg::*;
#(
  parameter int unsigned SyncStages = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            meip_i,
  input  logic            mtip_i,
  input  logic            msip_i,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [Xlen-1:0] csr_wdata_i,
  output logic [Xlen-1:0] csr_rdata_o,
  output logic            irq_req_o,
  output logic [Xlen-1:0] irq_cause_o,
  input  logic            irq_ack_i,
  input  logic            expt_taken_i,
  input  logic            mret_i
);

  typedef enum logic {
    IDLE,
    REQ
  } irq_state_e;

  localparam int unsigned CauseIdxW = $clog2(Xlen);

  logic            meip_sync, mtip_sync, msip_sync;
  logic [Xlen-1:0] mip, mie_q, mie_d, eligible, cause_q;
  logic            mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
  logic            wr_mstatus, wr_mie, trap, latched_eligible, latch_cause;
  irq_state_e      state_q, state_d;

  sync_ff #(.Depth(SyncStages)) u_sync_mei (.clk_i, .rst_ni, .d(meip_i), .q(meip_sync));
  sync_ff #(.Depth(SyncStages)) u_sync_mti (.clk_i, .rst_ni, .d(mtip_i), .q(mtip_sync));
  sync_ff #(.Depth(SyncStages)) u_sync_msi (.clk_i, .rst_ni, .d(msip_i), .q(msip_sync));

  always_comb begin
    mip            = '0;
    mip[IntBitMEI] = meip_sync;
    mip[IntBitMTI] = mtip_sync;
    mip[IntBitMSI] = msip_sync;
  end

  assign wr_mstatus = csr_we_i && (csr_addr_i == CSRmstatus);
  assign wr_mie     = csr_we_i && (csr_addr_i == CSRmie);
  assign trap       = irq_ack_i || expt_taken_i;

  // Trap entry outranks MRET, which outranks a CSR write to mstatus.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    if (trap) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (wr_mstatus) begin
      mstatus_mie_d  = csr_wdata_i[MstatusMIE];
      mstatus_mpie_d = csr_wdata_i[MstatusMPIE];
    end
  end

  assign mie_d = wr_mie ? (csr_wdata_i & IntMask) : mie_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
    end
  end

  // Eligibility looks at this cycle's enable updates so a write takes effect next cycle.
  assign eligible         = mip & mie_d & {Xlen{mstatus_mie_d}};
  assign latched_eligible = eligible[cause_q[CauseIdxW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (|eligible) state_d = REQ;
      REQ:  if (irq_ack_i || !latched_eligible) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    irq_req_o   = (state_q == REQ);
    latch_cause = (state_q == IDLE) && (|eligible);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cause_q <= '0;
    end else if (latch_cause) begin
      cause_q <= irq_select(eligible);
    end
  end

  assign irq_cause_o = cause_q;

  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSRmstatus: begin
        csr_rdata_o[MstatusMIE]  = mstatus_mie_q;
        csr_rdata_o[MstatusMPIE] = mstatus_mpie_q;
      end
      CSRmie:  csr_rdata_o = mie_q;
      CSRmip:  csr_rdata_o = mip;
      default: csr_rdata_o = '0;
    endcase
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Machine-mode interrupt controller that sits beside the CSR file and in front of the pipeline's trap path. It owns `mstatus.MIE/MPIE`, `mie` and the read-only `mip`, and synchronizes the three machine interrupt lines. It selects the highest-priority enabled pending interrupt and presents it to the pipeline through a request/acknowledge handshake. The pipeline then forwards the cause into the CSR file's exception port at an instruction boundary.

## Interface
- `SyncStages`, default 2: number of flip-flop stages in each interrupt-line synchronizer; legal range 2–4.
- `clk_i` input 1: the single clock.
- `rst_ni` input 1: reset, asynchronous and active-low.
- `meip_i`, `mtip_i`, `msip_i` input 1 each: asynchronous level-sensitive external, timer and software interrupt lines.
- `csr_we_i` input 1: CSR write strobe, one cycle per retired CSR write.
- `csr_addr_i` input 12: CSR address, used for both reads and writes.
- `csr_wdata_i` input Xlen: final write value, with RS/RC already resolved by the CSR datapath.
- `csr_rdata_o` output Xlen: combinational read of `mstatus`, `mie` or `mip`; reads 0 for any other address.
- `irq_req_o` output 1: interrupt request to the pipeline.
- `irq_cause_o` output Xlen: `mcause` value for the request; bit Xlen-1 set, low bits hold the code.
- `irq_ack_i` input 1: the pipeline took the requested trap this cycle.
- `expt_taken_i` input 1: a synchronous exception trap was taken this cycle.
- `mret_i` input 1: MRET retired this cycle.

## Operation
- **Synchronizers.** Each line passes through a `SyncStages`-deep synchronizer. The synchronized levels drive `mip.MEIP` (bit 11), `mip.MTIP` (bit 7) and `mip.MSIP` (bit 3). `mip` is read-only; writes to it are ignored.
- **`mie`.** Only bits 11, 7 and 3 are implemented. All other bits read 0 and ignore writes.
- **`mstatus`.** Only MIE (bit 3) and MPIE (bit 7) are implemented. All other bits read 0.
- **Eligibility.** `eligible = mip & mie`, gated by `mstatus.MIE`.
- **Priority (fixed).** MEI (code 11) > MSI (code 3) > MTI (code 7).
- **State machine, IDLE.** `irq_req_o` = 0. If any source is eligible, the highest-priority cause is latched into `irq_cause_o` and the FSM moves to REQ.
- **State machine, REQ.** `irq_req_o` = 1 and `irq_cause_o` is held stable until the request leaves REQ.
  - `irq_ack_i` → IDLE.
  - The latched source is no longer eligible (line dropped, `mie` bit cleared, or MIE cleared) and there is no ack → IDLE, request withdrawn.
  - A higher-priority source becoming eligible does NOT replace the latched cause.
- **Trap entry.** On `irq_ack_i` or `expt_taken_i`: MPIE ← MIE, then MIE ← 0.
- **MRET.** MIE ← MPIE, then MPIE ← 1.
- **Write priority.** When several updates hit the same register in one cycle: ack/`expt_taken_i` > `mret_i` > CSR write. Lower-priority updates are dropped.
- **Ack outside REQ.** `irq_ack_i` while in IDLE is a protocol error. The FSM ignores it and still applies the trap-entry status update.

## Timing
- **Reset values.** `mstatus` = 0, `mie` = 0, all synchronizer stages = 0, FSM = IDLE, `irq_req_o` = 0, `irq_cause_o` = 0.
- **Pin to request.** A line rising with `mie` and MIE set gives `irq_req_o` = 1 exactly `SyncStages`+1 cycles later.
- **Enable to request.** A CSR write that enables an already-pending source gives `irq_req_o` = 1 on the cycle after the write.
- **Ack.** `irq_req_o` falls the cycle after `irq_ack_i`. MIE reads 0 in that same cycle, so there is no back-to-back re-request.
- **Withdrawal.** `irq_req_o` falls the cycle after the latched source loses eligibility.
- **Read path.** `csr_rdata_o` is purely combinational from registered state. The value written in cycle N is visible in cycle N+1.
- **Reset mid-request.** Reset drops `irq_req_o` asynchronously. The pipeline must treat a request lost this way as never issued.

## Structure
- **`csr_pkg` additions.**
  - `CSRmstatus`, `CSRmie` and `CSRmip` address constants.
  - Interrupt bit-position constants (3, 7, 11).
  - `IntCauseMEI`, `IntCauseMSI` and `IntCauseMTI` constants as full Xlen `mcause` values with the interrupt bit set.
- **`irq_state_e`** (IDLE, REQ) lives locally in the module.
- **`sync_ff` sub-module** (parameterized depth, async active-low reset) is instantiated three times. It is reusable elsewhere in the core.

## Test plan
- Reset, then read `mstatus`, `mie` and `mip` → all 0. `irq_req_o` = 0 with all three lines high.
- Write `mie` = 0x880, set MIE, raise `mtip_i` → `irq_req_o` = 1 after 3 cycles (`SyncStages`=2) with cause 0x8000…0007. Ack → request drops and `mstatus` reads 0x80.
- Raise `mtip_i` and `meip_i` together, all enabled → cause 0x8000…000B. MRET, then `mtip_i` still high → new request with cause 0x8000…0007.
- Request pending with MTI; CSR write clears `mie` bit 7 → request withdrawn next cycle, no ack needed.
- Same cycle: `irq_ack_i` and CSR write setting MIE → MIE ends 0, MPIE 1.
- Assert `rst_ni` low mid-REQ, asynchronously off a clock edge → `irq_req_o` = 0 immediately and all CSRs return to 0.
